// File: rtl/fft_pkg.sv
// Shared types and defaults for the two-requester FFT frame scheduler.
package fft_pkg;
    localparam int N_POINT_DEF = 1024;
    localparam int SAMPLE_W    = 32;

    typedef enum logic {
        IDLE = 1'b0,
        FEED = 1'b1
    } state_e;

    // Requester id: 0 = s0/m0, 1 = s1/m1.
    typedef logic chan_t;

    // Round-robin pick: on a tie the channel not granted last wins,
    // otherwise the only requesting channel is taken.
    function automatic chan_t pick_chan(input logic v0, input logic v1, input chan_t last);
        if (v0 && v1) begin
            return ~last;
        end else if (v1) begin
            return 1'b1;
        end else begin
            return 1'b0;
        end
    endfunction
endpackage

// File: rtl/fft_tag_fifo.sv
// Owner-tag FIFO: remembers which requester owns each frame inside the FFT core.
module fft_tag_fifo
    import fft_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  n_reset,
    input  logic  push,
    input  chan_t push_data,
    input  logic  pop,
    output chan_t head,
    output logic  full,
    output logic  empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    chan_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    // A push is refused when full even if a pop lands in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Tag storage; contents are only meaningful while count_q covers them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/fft_sched.sv
// Frame-granular round-robin scheduler feeding one FFT core from two requesters
// and routing results back to the frame owner.
module fft_sched
    import fft_pkg::*;
#(
    parameter int N_POINT   = N_POINT_DEF,
    parameter int GAP       = 6,
    parameter int OWN_DEPTH = 4
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                s0_valid,
    input  logic [SAMPLE_W-1:0] s0_data,
    output logic                s0_ready,
    input  logic                s1_valid,
    input  logic [SAMPLE_W-1:0] s1_data,
    output logic                s1_ready,
    output logic                fft_i_strb,
    output logic [SAMPLE_W-1:0] fft_i_data,
    input  logic                fft_o_strb,
    input  logic [SAMPLE_W-1:0] fft_o_data,
    output logic                m0_strb,
    output logic                m1_strb,
    output logic [SAMPLE_W-1:0] m_data,
    output logic                busy,
    output logic                err_orphan
);
    localparam int CNT_W = $clog2(N_POINT);
    localparam int GAP_W = $clog2(GAP + 1);

    state_e              state_q, state_d;
    chan_t               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    in_cnt_q, in_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic                fi_strb_q, fi_strb_d;
    logic [SAMPLE_W-1:0] fi_data_q, fi_data_d;
    logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
    logic                m0_q, m0_d;
    logic                m1_q, m1_d;
    logic [SAMPLE_W-1:0] m_data_q, m_data_d;
    logic                err_q, err_d;

    logic                grant;
    chan_t               grant_ch;
    logic                feed_ready;
    logic                src_valid;
    logic [SAMPLE_W-1:0] src_data;
    logic                hs;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    chan_t               head;

    // While feeding, the current owner is the channel granted last.
    assign src_valid  = last_grant_q ? s1_valid : s0_valid;
    assign src_data   = last_grant_q ? s1_data : s0_data;
    assign feed_ready = (state_q == FEED) && (gap_cnt_q == '0);
    assign s0_ready   = feed_ready && !last_grant_q;
    assign s1_ready   = feed_ready && last_grant_q;
    assign hs         = feed_ready && src_valid;
    assign grant_ch   = pick_chan(s0_valid, s1_valid, last_grant_q);
    assign grant      = (state_q == IDLE) && (s0_valid || s1_valid) && !fifo_full;

    assign fft_i_strb = fi_strb_q;
    assign fft_i_data = fi_data_q;
    assign m0_strb    = m0_q;
    assign m1_strb    = m1_q;
    assign m_data     = m_data_q;
    assign err_orphan = err_q;
    assign busy       = (state_q == FEED) || !fifo_empty;

    fft_tag_fifo #(
        .DEPTH (OWN_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .n_reset   (n_reset),
        .push      (grant),
        .push_data (grant_ch),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Input side: grant a whole frame, then pace samples GAP cycles apart.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        in_cnt_d     = in_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        fi_strb_d    = 1'b0;
        fi_data_d    = fi_data_q;
        if (gap_cnt_q != '0) begin
            gap_cnt_d = gap_cnt_q - 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d      = FEED;
                    last_grant_d = grant_ch;
                    in_cnt_d     = '0;
                    gap_cnt_d    = '0;
                end
            end
            FEED: begin
                if (hs) begin
                    fi_strb_d = 1'b1;
                    fi_data_d = src_data;
                    gap_cnt_d = GAP_W'(GAP - 1);
                    in_cnt_d  = in_cnt_q + 1'b1;
                    if (in_cnt_q == CNT_W'(N_POINT - 1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output side: route each result to the owner at the FIFO head; last sample pops.
    always_comb begin
        m0_d      = 1'b0;
        m1_d      = 1'b0;
        m_data_d  = m_data_q;
        out_cnt_d = out_cnt_q;
        err_d     = err_q;
        fifo_pop  = 1'b0;
        if (fft_o_strb) begin
            if (fifo_empty) begin
                err_d = 1'b1;
            end else begin
                m_data_d  = fft_o_data;
                m0_d      = (head == 1'b0);
                m1_d      = (head == 1'b1);
                out_cnt_d = out_cnt_q + 1'b1;
                if (out_cnt_q == CNT_W'(N_POINT - 1)) begin
                    fifo_pop = 1'b1;
                end
            end
        end
    end

    // State registers; last_grant resets to 1 so channel 0 wins the first tie.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            in_cnt_q     <= '0;
            gap_cnt_q    <= '0;
            fi_strb_q    <= 1'b0;
            fi_data_q    <= '0;
            out_cnt_q    <= '0;
            m0_q         <= 1'b0;
            m1_q         <= 1'b0;
            m_data_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            in_cnt_q     <= in_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            fi_strb_q    <= fi_strb_d;
            fi_data_q    <= fi_data_d;
            out_cnt_q    <= out_cnt_d;
            m0_q         <= m0_d;
            m1_q         <= m1_d;
            m_data_q     <= m_data_d;
            err_q        <= err_d;
        end
    end
endmodule

// File: tb/tb_fft_sched.sv
// Self-checking bench for fft_sched: random sample data, expectations from a
// frame-level model (frame ownership order, pacing, routing of results).
module tb_fft_sched;
    // Frame size kept small so several frames fit in a short run.
    localparam int N       = 128;
    localparam int GAP     = 6;
    localparam int DEPTH   = 4;
    localparam int SRC_LEN = 6 * N;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        s0_valid = 1'b0, s1_valid = 1'b0;
    logic [31:0] s0_data = '0, s1_data = '0;
    logic        s0_ready, s1_ready;
    logic        fft_i_strb;
    logic [31:0] fft_i_data;
    logic        fft_o_strb = 1'b0;
    logic [31:0] fft_o_data = '0;
    logic        m0_strb, m1_strb;
    logic [31:0] m_data;
    logic        busy, err_orphan;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] src [2][SRC_LEN];
    int          idx [2];
    int          fi_cyc[$];
    logic [31:0] fi_dat[$];
    int          hs_ch[$];
    int          hs_cyc[$];
    int          m_cyc[$];
    int          m_ch[$];
    logic [31:0] m_dat[$];
    int          both_ready_cnt, both_m_cnt, busy_low_cnt;

    fft_sched #(
        .N_POINT   (N),
        .GAP       (GAP),
        .OWN_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .s0_valid   (s0_valid),
        .s0_data    (s0_data),
        .s0_ready   (s0_ready),
        .s1_valid   (s1_valid),
        .s1_data    (s1_data),
        .s1_ready   (s1_ready),
        .fft_i_strb (fft_i_strb),
        .fft_i_data (fft_i_data),
        .fft_o_strb (fft_o_strb),
        .fft_o_data (fft_o_data),
        .m0_strb    (m0_strb),
        .m1_strb    (m1_strb),
        .m_data     (m_data),
        .busy       (busy),
        .err_orphan (err_orphan)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_records();
        fi_cyc.delete(); fi_dat.delete(); hs_ch.delete(); hs_cyc.delete();
        m_cyc.delete(); m_ch.delete(); m_dat.delete();
        both_ready_cnt = 0; both_m_cnt = 0; busy_low_cnt = 0;
        idx[0] = 0; idx[1] = 0;
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < SRC_LEN; k++)
                src[c][k] = $urandom;
        s0_data = src[0][0];
        s1_data = src[1][0];
    endtask

    // One clock: note handshakes due at the edge, then record what the DUT shows after it.
    task automatic step();
        bit h0, h1;
        h0 = s0_valid && s0_ready;
        h1 = s1_valid && s1_ready;
        if (s0_ready && s1_ready) both_ready_cnt++;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (h0) begin idx[0]++; hs_ch.push_back(0); hs_cyc.push_back(cyc); end
        if (h1) begin idx[1]++; hs_ch.push_back(1); hs_cyc.push_back(cyc); end
        if (fft_i_strb) begin fi_cyc.push_back(cyc); fi_dat.push_back(fft_i_data); end
        if (m0_strb || m1_strb) begin
            m_cyc.push_back(cyc); m_ch.push_back(m1_strb ? 1 : 0); m_dat.push_back(m_data);
        end
        if (m0_strb && m1_strb) both_m_cnt++;
        if (!busy) busy_low_cnt++;
        s0_data = src[0][idx[0] % SRC_LEN];
        s1_data = src[1][idx[1] % SRC_LEN];
        #1;
    endtask

    task automatic apply_reset();
        s0_valid = 1'b0; s1_valid = 1'b0; fft_o_strb = 1'b0;
        @(negedge clk);
        n_reset = 1'b0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        s0_valid = 1'b1; s1_valid = 1'b1; fft_o_strb = 1'b1;
        fft_o_data = $urandom; s0_data = $urandom; s1_data = $urandom;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({s0_ready, s1_ready, fft_i_strb, m0_strb, m1_strb, busy, err_orphan} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0000000",
                     {s0_ready, s1_ready, fft_i_strb, m0_strb, m1_strb, busy, err_orphan});
        end
        checks++;
        if (fft_i_data !== 32'h0) begin
            errors++; $display("FAIL reset_fft_i_data got %h want 0", fft_i_data);
        end
        checks++;
        if (m_data !== 32'h0) begin
            errors++; $display("FAIL reset_m_data got %h want 0", m_data);
        end
        s0_valid = 1'b0; s1_valid = 1'b0; fft_o_strb = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        #1;
        clear_records();
        repeat (3) step();
        checks++;
        if (busy_low_cnt != 3 || both_ready_cnt != 0 || err_orphan !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy_low %0d err %b want 3 0", busy_low_cnt, err_orphan);
        end
        $display("test_reset done");
    endtask

    task automatic test_orphan();
        clear_records();
        fft_o_strb = 1'b1; fft_o_data = $urandom;
        step();
        fft_o_strb = 1'b0;
        checks++;
        if (err_orphan !== 1'b1) begin
            errors++; $display("FAIL orphan_flag got %b want 1", err_orphan);
        end
        repeat (5) step();
        checks++;
        if (err_orphan !== 1'b1) begin
            errors++; $display("FAIL orphan_sticky got %b want 1", err_orphan);
        end
        checks++;
        if (m_cyc.size() != 0) begin
            errors++; $display("FAIL orphan_no_mstrb got %0d strobes want 0", m_cyc.size());
        end
        apply_reset();
        checks++;
        if (err_orphan !== 1'b0) begin
            errors++; $display("FAIL orphan_cleared got %b want 0", err_orphan);
        end
        $display("test_orphan done");
    endtask

    task automatic test_single_stream();
        int bad, bad_k, gap_bad, ch1_cnt;
        apply_reset();
        clear_records();
        s0_valid = 1'b1;
        for (int i = 0; i < N * GAP + 40 && fi_cyc.size() < N; i++) step();
        s0_valid = 1'b0;
        repeat (GAP + 4) step();
        checks++;
        if (fi_cyc.size() != N) begin
            errors++; $display("FAIL single_count got %0d want %0d", fi_cyc.size(), N);
        end
        bad = 0; bad_k = -1;
        for (int k = 0; k < fi_dat.size() && k < N; k++)
            if (fi_dat[k] !== src[0][k]) begin bad++; if (bad_k < 0) bad_k = k; end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL single_data got %0d bad samples (first %0d) want 0", bad, bad_k);
        end
        gap_bad = 0;
        for (int k = 1; k < fi_cyc.size(); k++)
            if (fi_cyc[k] - fi_cyc[k-1] != GAP) gap_bad++;
        checks++;
        if (gap_bad != 0) begin
            errors++; $display("FAIL single_spacing got %0d bad gaps want 0", gap_bad);
        end
        ch1_cnt = 0;
        foreach (hs_ch[k]) if (hs_ch[k] != 0) ch1_cnt++;
        checks++;
        if (ch1_cnt != 0 || busy_low_cnt != 0) begin
            errors++;
            $display("FAIL single_busy_owner ch1_hs %0d busy_low %0d want 0 0", ch1_cnt, busy_low_cnt);
        end
        $display("test_single_stream done strobes=%0d", fi_cyc.size());
    endtask

    task automatic test_round_robin();
        int exp_ch[$];
        logic [31:0] exp_dat[$];
        int pos [2];
        int bad_ch, bad_dat, bad_m;
        int pulse_cyc[$];
        logic [31:0] pulse_dat[$];
        apply_reset();
        clear_records();
        s0_valid = 1'b1; s1_valid = 1'b1;
        for (int i = 0; i < 3 * (N * GAP + 10) && hs_ch.size() < 3 * N; i++) step();
        s0_valid = 1'b0; s1_valid = 1'b0;
        repeat (GAP + 4) step();
        // Frames alternate 0,1,0 starting with channel 0; each takes N samples in order.
        pos[0] = 0; pos[1] = 0;
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < N; k++) begin
                exp_ch.push_back(f % 2);
                exp_dat.push_back(src[f % 2][pos[f % 2]]);
                pos[f % 2]++;
            end
        checks++;
        if (hs_ch.size() != 3 * N || fi_dat.size() != 3 * N) begin
            errors++; $display("FAIL rr_count got %0d/%0d want %0d", hs_ch.size(), fi_dat.size(), 3 * N);
        end
        bad_ch = 0; bad_dat = 0;
        for (int k = 0; k < hs_ch.size() && k < 3 * N; k++) if (hs_ch[k] != exp_ch[k]) bad_ch++;
        for (int k = 0; k < fi_dat.size() && k < 3 * N; k++) if (fi_dat[k] !== exp_dat[k]) bad_dat++;
        checks++;
        if (bad_ch != 0) begin
            errors++; $display("FAIL rr_owner_order got %0d wrong-channel samples want 0", bad_ch);
        end
        checks++;
        if (bad_dat != 0) begin
            errors++; $display("FAIL rr_data got %0d wrong samples want 0", bad_dat);
        end
        checks++;
        if (both_ready_cnt != 0) begin
            errors++; $display("FAIL rr_single_ready got %0d cycles both ready want 0", both_ready_cnt);
        end
        // Results: first frame back to channel 0, second to channel 1.
        m_cyc.delete(); m_ch.delete(); m_dat.delete(); both_m_cnt = 0;
        for (int k = 0; k < 2 * N; k++) begin
            fft_o_strb = 1'b1;
            fft_o_data = $urandom;
            pulse_cyc.push_back(cyc + 1);
            pulse_dat.push_back(fft_o_data);
            step();
            fft_o_strb = 1'b0;
            repeat ($urandom_range(0, 2)) step();
        end
        step();
        checks++;
        if (m_cyc.size() != 2 * N) begin
            errors++; $display("FAIL out_count got %0d want %0d", m_cyc.size(), 2 * N);
        end
        bad_m = 0;
        for (int k = 0; k < m_cyc.size() && k < 2 * N; k++)
            if (m_ch[k] != (k < N ? 0 : 1) || m_cyc[k] != pulse_cyc[k] || m_dat[k] !== pulse_dat[k])
                bad_m++;
        checks++;
        if (bad_m != 0) begin
            errors++; $display("FAIL out_route got %0d bad results want 0", bad_m);
        end
        checks++;
        if (both_m_cnt != 0 || busy !== 1'b1 || err_orphan !== 1'b0) begin
            errors++;
            $display("FAIL out_status both_m %0d busy %b err %b want 0 1 0", both_m_cnt, busy, err_orphan);
        end
        $display("test_round_robin done inputs=%0d outputs=%0d", hs_ch.size(), m_cyc.size());
    endtask

    task automatic test_fifo_full();
        int last_pulse, bad_m;
        apply_reset();
        clear_records();
        s0_valid = 1'b1;
        for (int i = 0; i < 4 * (N * GAP + 10) && hs_ch.size() < 4 * N; i++) step();
        repeat (3 * GAP + 20) step();
        checks++;
        if (hs_ch.size() != 4 * N || s0_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_block got %0d handshakes ready %b want %0d 0", hs_ch.size(), s0_ready, 4 * N);
        end
        last_pulse = 0;
        for (int k = 0; k < N; k++) begin
            fft_o_strb = 1'b1;
            fft_o_data = $urandom;
            last_pulse = cyc + 1;
            step();
        end
        fft_o_strb = 1'b0;
        for (int i = 0; i < 20 && hs_ch.size() <= 4 * N; i++) step();
        checks++;
        if (hs_cyc.size() <= 4 * N) begin
            errors++; $display("FAIL full_resume got %0d handshakes want more than %0d", hs_cyc.size(), 4 * N);
        end else if (hs_cyc[4 * N] - last_pulse != 2) begin
            errors++;
            $display("FAIL full_resume_delay got %0d cycles want 2", hs_cyc[4 * N] - last_pulse);
        end
        bad_m = 0;
        foreach (m_ch[k]) if (m_ch[k] != 0) bad_m++;
        checks++;
        if (m_cyc.size() != N || bad_m != 0 || err_orphan !== 1'b0) begin
            errors++;
            $display("FAIL full_drain got %0d results %0d on ch1 err %b want %0d 0 0",
                     m_cyc.size(), bad_m, err_orphan, N);
        end
        s0_valid = 1'b0;
        $display("test_fifo_full done handshakes=%0d", hs_ch.size());
    endtask

    task automatic test_reset_midframe();
        apply_reset();
        clear_records();
        s0_valid = 1'b1;
        for (int i = 0; i < N * GAP && hs_ch.size() < N / 2; i++) step();
        #2;
        n_reset = 1'b0;
        #1;
        checks++;
        if ({s0_ready, s1_ready, fft_i_strb, m0_strb, m1_strb, busy, err_orphan} !== 7'b0
            || fft_i_data !== 32'h0 || m_data !== 32'h0) begin
            errors++;
            $display("FAIL midframe_reset ctrl %b fft_i_data %h m_data %h want all 0",
                     {s0_ready, s1_ready, fft_i_strb, m0_strb, m1_strb, busy, err_orphan},
                     fft_i_data, m_data);
        end
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        clear_records();
        #1;
        for (int i = 0; i < 2 * N * GAP && hs_ch.size() < N + 1; i++) step();
        s0_valid = 1'b0;
        step();
        checks++;
        if (fi_dat.size() == 0 || fi_dat[0] !== src[0][0]) begin
            errors++; $display("FAIL restart_first_sample got %0d strobes want first sample %h", fi_dat.size(), src[0][0]);
        end
        checks++;
        if (hs_cyc.size() < N + 1) begin
            errors++; $display("FAIL restart_count got %0d want %0d", hs_cyc.size(), N + 1);
        end else if (hs_cyc[N] - hs_cyc[N-1] != 2 || hs_cyc[N-1] - hs_cyc[N-2] != GAP) begin
            errors++;
            $display("FAIL restart_frame_edge got %0d/%0d want 2/%0d",
                     hs_cyc[N] - hs_cyc[N-1], hs_cyc[N-1] - hs_cyc[N-2], GAP);
        end
        $display("test_reset_midframe done");
    endtask

    initial begin
        test_reset();
        test_orphan();
        test_single_stream();
        test_round_robin();
        test_fifo_full();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_sched.md
FFT_SCHED -- requirements
Module: fft_sched

Interface
REQ-001 Parameter N_POINT, default 1024, samples per FFT frame (power of two).
REQ-002 Parameter GAP, default 6, minimum clock cycles between consecutive fft_i_strb pulses (>=1).
REQ-003 Parameter OWN_DEPTH, default 4, owner-tag FIFO depth, i.e. maximum frames in flight.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 n_reset  in  1  asynchronous, active-low reset.
REQ-006 s0_valid / s1_valid  in  1  requester 0/1 has an input sample.
REQ-007 s0_data / s1_data  in  32  requester 0/1 sample, {re[15:0], im[15:0]} passed unmodified.
REQ-008 s0_ready / s1_ready  out  1  sample accepted when valid & ready in the same cycle.
REQ-009 fft_i_strb  out  1  one-cycle input strobe to the FFT core.
REQ-010 fft_i_data  out  32  FFT input sample, valid while fft_i_strb=1.
REQ-011 fft_o_strb  in  1  one-cycle output strobe from the FFT core.
REQ-012 fft_o_data  in  32  FFT output sample, valid with fft_o_strb.
REQ-013 m0_strb / m1_strb  out  1  result sample for requester 0/1.
REQ-014 m_data  out  32  shared result data, valid while either m*_strb=1.
REQ-015 busy  out  1  high while in FEED or owner FIFO non-empty.
REQ-016 err_orphan  out  1  sticky: fft_o_strb arrived with owner FIFO empty.

Function
REQ-017 Input FSM has two states, IDLE and FEED; arbitration granularity is one whole frame.
REQ-018 IDLE->FEED when (s0_valid|s1_valid) and owner FIFO not full; grant round-robin: if both valid, grant the channel not granted last; single valid granted directly.
REQ-019 On grant, push granted channel id into owner FIFO, clear in_cnt, clear gap_cnt, record last_grant.
REQ-020 In FEED, s<owner>_ready = (gap_cnt==0); the other channel's ready=0; both ready=0 in IDLE.
REQ-021 On handshake: register data to fft_i_data and assert fft_i_strb next cycle for exactly one cycle; reload gap_cnt=GAP-1; increment in_cnt.
REQ-022 gap_cnt decrements by 1 per cycle when non-zero; strobe spacing is therefore >=GAP cycles, equal to GAP when source is always valid.
REQ-023 Handshake with in_cnt==N_POINT-1 -> IDLE; new grant earliest the following cycle.
REQ-024 Requester deasserting valid mid-frame stalls FEED indefinitely; no timeout, no regrant.
REQ-025 Output: on fft_o_strb, register fft_o_data to m_data and assert m<head>_strb next cycle for one cycle; increment out_cnt (log2(N_POINT) bits, wraps).
REQ-026 The N_POINT-th output of a frame pops the owner FIFO and clears out_cnt.
REQ-027 fft_o_strb with FIFO empty: no m*_strb, set err_orphan, out_cnt unchanged.
REQ-028 Grant and pop in same cycle allowed when FIFO not full before the cycle; full FIFO blocks grant even if pop coincides.
REQ-029 m0_strb and m1_strb never high together; fft_i_strb never high on two consecutive cycles when GAP>=2.

Reset
REQ-030 n_reset low: state=IDLE, in_cnt=out_cnt=gap_cnt=0, owner FIFO empty, last_grant=1 (channel 0 wins first tie).
REQ-031 Reset values: all strobes, readies, busy, err_orphan = 0; fft_i_data, m_data = 0.
REQ-032 Reset mid-frame discards partial frame and all tags; no recovery of the FFT core state is attempted.

Structure
REQ-033 Shared package fft_pkg holds N_POINT default, sample width 32, state enum {IDLE, FEED}, channel-id type.
REQ-034 Owner-tag FIFO is one sub-module, fft_tag_fifo (depth OWN_DEPTH, width 1, push/pop/full/empty).

Verification
REQ-035 s0 always valid, s1 idle, N_POINT=1024, GAP=6 -> 1024 fft_i_strb pulses exactly 6 cycles apart, data in order, busy=1.
REQ-036 Both valid from reset -> frame 0 to ch0, frame 1 to ch1, frame 2 to ch0; s1_ready stays 0 during ch0 frame.
REQ-037 Model FFT returns frames in order -> first 1024 outputs on m0_strb only, next 1024 on m1_strb only, m_data = fft_o_data delayed one cycle.
REQ-038 Hold fft_o_strb idle with OWN_DEPTH=4 -> 4 frames accepted, 5th grant blocked (ready=0) until first output frame completes.
REQ-039 fft_o_strb pulse after reset with no grant -> err_orphan=1 sticky, m0/m1_strb=0.
REQ-040 Assert n_reset=0 at in_cnt=500 -> all outputs 0 within same cycle; after release, next grant restarts in_cnt at 0.
